core_prefetch_queue: RTL and testbench

//   Parametrised instruction prefetch queue for the core fetch stage. Reads opcode bytes ahead

---
 rtl/core_prefetch_queue_if.sv | 27 ++
 rtl/core_prefetch_queue.sv | 125 ++++++++++++
 tb/tb_core_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_prefetch_queue_if.sv
// Fetch-side bus of the prefetch queue: byte-wide memory read port plus head-of-queue port.
// master = queue, slave = memory/sequencer side.
interface core_prefetch_queue_if #(
  parameter int AW = 20
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [7:0]    mem_in;
  logic          q_valid;
  logic [7:0]    q_byte;
  logic [AW-1:0] q_eip;
  logic          q_pop;
  logic [4:0]    q_count;
  logic [8:0]    q_prefix;
  logic [3:0]    q_psize;

  modport master (
    output mem_req, mem_addr, q_valid, q_byte, q_eip, q_count, q_prefix, q_psize,
    input  mem_ready, mem_in, q_pop
  );

  modport slave (
    input  mem_req, mem_addr, q_valid, q_byte, q_eip, q_count, q_prefix, q_psize,
    output mem_ready, mem_in, q_pop
  );
endinterface

// File: rtl/core_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-byte circular buffer filled ahead over a byte-wide port.
// Define CORE_PREFETCH_PREFIX_EN to strip x86 prefix bytes at the head and present them decoded.
module core_prefetch_queue #(
  parameter int            DEPTH     = 4,
  parameter int            AW        = 20,
  parameter logic [AW-1:0] RESET_EIP = AW'('hF8000)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [AW-1:0]        flush_eip,
  core_prefetch_queue_if.master bus
);
  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [DEPTH-1:0][7:0] data_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [4:0]            count_q;
  logic [AW-1:0]         fetch_eip_q, head_eip_q;
  logic [7:0]            head_byte;
  logic                  non_empty, xfer, pop, strip, consume;

  assign head_byte    = data_q[head_q];
  assign non_empty    = count_q != 5'd0;
  assign bus.mem_req  = !flush && (count_q < DEPTH_C);
  assign bus.mem_addr = fetch_eip_q;
  assign bus.q_byte   = head_byte;
  assign bus.q_count  = count_q;
  assign xfer         = bus.mem_req && bus.mem_ready;
  assign pop          = bus.q_pop && bus.q_valid;
  // a stripped prefix leaves the buffer exactly like a pop
  assign consume      = pop || strip;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_eip_q <= RESET_EIP;
      head_eip_q  <= RESET_EIP;
    end else if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_eip_q <= flush_eip;
      head_eip_q  <= flush_eip;
    end else begin
      if (xfer) begin
        data_q[tail_q] <= bus.mem_in;
        tail_q         <= tail_q + 1'b1;
        fetch_eip_q    <= fetch_eip_q + 1'b1;
      end
      if (consume) begin
        head_q     <= head_q + 1'b1;
        head_eip_q <= head_eip_q + 1'b1;
      end
      count_q <= count_q + {4'd0, xfer} - {4'd0, consume};
    end
  end

`ifdef CORE_PREFETCH_PREFIX_EN
  typedef struct packed {
    logic       opext;
    logic [1:0] rep;
    logic       lock;
    logic       adsize;
    logic       opsize;
    logic [2:0] seg;
  } pfx_t;

  pfx_t          acc_q, acc_nxt;
  logic [3:0]    psize_q;
  logic [AW-1:0] start_eip_q;
  logic          opcode_next_q;
  logic          head_is_pfx;

  always_comb begin
    head_is_pfx = 1'b1;
    acc_nxt     = acc_q;
    case (head_byte)
      8'h26:        acc_nxt.seg    = 3'd1;
      8'h2E:        acc_nxt.seg    = 3'd2;
      8'h36:        acc_nxt.seg    = 3'd3;
      8'h3E:        acc_nxt.seg    = 3'd4;
      8'h64:        acc_nxt.seg    = 3'd5;
      8'h65:        acc_nxt.seg    = 3'd6;
      8'h66:        acc_nxt.opsize = !acc_q.opsize;
      8'h67:        acc_nxt.adsize = !acc_q.adsize;
      8'hF0:        acc_nxt.lock   = 1'b1;
      8'hF2, 8'hF3: acc_nxt.rep    = head_byte[1:0];
      8'h0F:        acc_nxt.opext  = 1'b1;
      default:      head_is_pfx    = 1'b0;
    endcase
  end

  // after 0F the next byte is the opcode even if it looks like a prefix
  assign strip        = non_empty && !opcode_next_q && head_is_pfx;
  assign bus.q_valid  = non_empty && !strip;
  assign bus.q_eip    = (psize_q == 4'd0) ? head_eip_q : start_eip_q;
  assign bus.q_prefix = acc_q;
  assign bus.q_psize  = psize_q;

  always_ff @(posedge clock) begin
    if (!reset_n || flush || pop) begin
      acc_q         <= '0;
      psize_q       <= '0;
      start_eip_q   <= '0;
      opcode_next_q <= 1'b0;
    end else if (strip) begin
      acc_q         <= acc_nxt;
      opcode_next_q <= head_byte == 8'h0F;
      if (psize_q != 4'd15) psize_q <= psize_q + 4'd1;
      if (psize_q == 4'd0) start_eip_q <= head_eip_q;
    end
  end
`else
  assign strip        = 1'b0;
  assign bus.q_valid  = non_empty;
  assign bus.q_eip    = head_eip_q;
  assign bus.q_prefix = '0;
  assign bus.q_psize  = '0;
`endif

endmodule

// File: tb/tb_core_prefetch_queue.sv
// Scoreboarded bench for core_prefetch_queue: byte/instruction stream model plus random stimulus.
module tb_core_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 20;
  typedef logic [AW-1:0] addr_t;
  typedef struct {
    logic [7:0] b;
    addr_t      eip;
    logic [8:0] pfx;
    logic [3:0] ps;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset_n, flush;
  addr_t flush_eip;

  core_prefetch_queue_if #(.AW(AW)) bus();

  core_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_EIP(20'hF8000)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .flush_eip(flush_eip), .bus(bus)
  );

  always #5 clock = ~clock;

  int         n_checks = 0, n_fail = 0;
  exp_t       exp_q[$];
  logic [7:0] rnd_mem [256];
  logic [7:0] ov [addr_t];
  logic [7:0] pfx_list [12] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                                8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h0F};
  addr_t      m_addr, m_start;
  int         m_cnt, m_ps;
  logic [8:0] m_pfx;
  logic       m_after0f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input addr_t a);
    if (ov.exists(a)) return ov[a];
    return rnd_mem[a[7:0] ^ a[15:8]];
  endfunction

  function automatic void model_reset(input addr_t a);
    m_addr = a; m_cnt = 0; exp_q.delete();
    m_pfx = '0; m_ps = 0; m_start = '0; m_after0f = 1'b0;
  endfunction

  // Turns the fetched byte stream into the sequence of items the head must present.
  function automatic void model_push(input addr_t a, input logic [7:0] b);
    exp_t e;
`ifdef CORE_PREFETCH_PREFIX_EN
    if (!m_after0f && (b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                                 8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h0F})) begin
      if (m_ps == 0) m_start = a;
      if (m_ps < 15) m_ps++;
      case (b)
        8'h26: m_pfx[2:0] = 3'd1;
        8'h2E: m_pfx[2:0] = 3'd2;
        8'h36: m_pfx[2:0] = 3'd3;
        8'h3E: m_pfx[2:0] = 3'd4;
        8'h64: m_pfx[2:0] = 3'd5;
        8'h65: m_pfx[2:0] = 3'd6;
        8'h66: m_pfx[3]   = ~m_pfx[3];
        8'h67: m_pfx[4]   = ~m_pfx[4];
        8'hF0: m_pfx[5]   = 1'b1;
        8'h0F: m_pfx[8]   = 1'b1;
        default: m_pfx[7:6] = b[1:0];
      endcase
      m_after0f = (b == 8'h0F);
    end else begin
      e.b = b; e.eip = (m_ps == 0) ? a : m_start; e.pfx = m_pfx; e.ps = 4'(m_ps);
      exp_q.push_back(e);
      m_pfx = '0; m_ps = 0; m_after0f = 1'b0;
    end
`else
    e.b = b; e.eip = a; e.pfx = '0; e.ps = '0;
    exp_q.push_back(e);
`endif
  endfunction

  // One clock: drive at negedge, check registered outputs, advance the model to post-edge state.
  task automatic cycle(input logic rn, input logic fl, input addr_t fe, input logic pop, input logic rdy);
    logic xfer;
    @(negedge clock);
    reset_n = rn; flush = fl; flush_eip = fe;
    bus.q_pop = pop; bus.mem_ready = rdy; bus.mem_in = mem_byte(m_addr);
    #1;
    if (rn) begin
`ifndef CORE_PREFETCH_PREFIX_EN
      chk("mem_req", 32'(bus.mem_req), 32'(!fl && m_cnt < DEPTH));
      chk("q_count", 32'(bus.q_count), 32'(m_cnt));
      chk("q_valid", 32'(bus.q_valid), 32'(m_cnt != 0));
`else
      if (fl) chk("mem_req_in_flush", 32'(bus.mem_req), 32'd0);
      if (bus.q_count > 5'(DEPTH)) chk("q_count_bound", 32'(bus.q_count), 32'(DEPTH));
`endif
      if (bus.mem_req) chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    end
    xfer = rn && !fl && rdy && bus.mem_req;
    if (!rn) model_reset(20'hF8000);
    else if (fl) model_reset(fe);
    else begin
      if (pop && m_cnt != 0) m_cnt--;
      if (xfer) begin
        model_push(m_addr, mem_byte(m_addr));
        m_addr++;
        m_cnt++;
      end
    end
  endtask

  // Monitor: every accepted head item is compared against the scoreboard front.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset_n === 1'b1 && flush === 1'b0 && bus.q_valid === 1'b1 && bus.q_pop === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL head_unexpected: got byte %0h eip %0h, expected no item", bus.q_byte, bus.q_eip);
        end else begin
          e = exp_q.pop_front();
          chk("head_byte",   32'(bus.q_byte),   32'(e.b));
          chk("head_eip",    32'(bus.q_eip),    32'(e.eip));
          chk("head_prefix", 32'(bus.q_prefix), 32'(e.pfx));
          chk("head_psize",  32'(bus.q_psize),  32'(e.ps));
        end
      end
    end
  end

  initial begin
    foreach (rnd_mem[i])
      rnd_mem[i] = ($urandom_range(0, 3) == 0) ? pfx_list[$urandom_range(0, 11)] : 8'($urandom);
    for (int i = 0; i < 4; i++) ov[20'hF8000 + 20'(i)] = 8'h90;
    ov[20'h00100] = 8'h66; ov[20'h00101] = 8'h2E; ov[20'h00102] = 8'hF3;
    ov[20'h00103] = 8'hA5; ov[20'h00104] = 8'h90;
    ov[20'h00200] = 8'h0F; ov[20'h00201] = 8'h66; ov[20'h00202] = 8'h90;
    reset_n = 1'b0; flush = 1'b0; flush_eip = '0;
    bus.q_pop = 1'b0; bus.mem_ready = 1'b0; bus.mem_in = '0;
    model_reset(20'hF8000);

    // reset with mem_ready high: the transfer must be ignored
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 1);
    chk("rst_q_count",  32'(bus.q_count),  32'd0);
    chk("rst_q_valid",  32'(bus.q_valid),  32'd0);
    chk("rst_q_psize",  32'(bus.q_psize),  32'd0);
    chk("rst_q_prefix", 32'(bus.q_prefix), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h000F8000);

    // fill from reset vector
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 1);
    chk("fill_q_count", 32'(bus.q_count), 32'd4);
    chk("fill_mem_req", 32'(bus.mem_req), 32'd0);
    chk("fill_q_eip",   32'(bus.q_eip),   32'h000F8000);
    chk("fill_q_byte",  32'(bus.q_byte),  32'h90);

    // streaming pops with memory always ready
    for (int i = 0; i < 8; i++) cycle(1, 0, '0, 1, 1);
    cycle(1, 0, '0, 0, 0);
`ifndef CORE_PREFETCH_PREFIX_EN
    chk("stream_q_eip", 32'(bus.q_eip), 32'h000F8008);
`endif

    // flush wins over pop and transfer in the same cycle
    cycle(1, 1, 20'h12345, 1, 1);
    cycle(1, 0, '0, 0, 1);
    chk("flush_q_count",  32'(bus.q_count),  32'd0);
    chk("flush_mem_addr", 32'(bus.mem_addr), 32'h00012345);
    chk("flush_q_valid",  32'(bus.q_valid),  32'd0);
    cycle(1, 0, '0, 0, 1);
`ifndef CORE_PREFETCH_PREFIX_EN
    chk("flush_lat_valid", 32'(bus.q_valid), 32'd1);
    chk("flush_lat_eip",   32'(bus.q_eip),   32'h00012345);
`endif

    // address wrap at 2^AW
    cycle(1, 1, 20'hFFFFE, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, '0, 0, 1);
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 0, 0);
`ifndef CORE_PREFETCH_PREFIX_EN
    chk("wrap_q_eip",  32'(bus.q_eip),  32'd0);
    chk("wrap_q_byte", 32'(bus.q_byte), 32'(mem_byte(20'h00000)));
`endif

    // 66 2E F3 A5
    cycle(1, 1, 20'h00100, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 1);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
`ifdef CORE_PREFETCH_PREFIX_EN
    chk("pfx_q_byte",   32'(bus.q_byte),   32'hA5);
    chk("pfx_q_eip",    32'(bus.q_eip),    32'h00100);
    chk("pfx_q_psize",  32'(bus.q_psize),  32'd3);
    chk("pfx_q_prefix", 32'(bus.q_prefix), 32'(9'b0_11_0_0_1_010));
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 0, 0);
    chk("pfx_pop_psize",  32'(bus.q_psize),  32'd0);
    chk("pfx_pop_prefix", 32'(bus.q_prefix), 32'd0);
`else
    chk("raw_q_byte", 32'(bus.q_byte), 32'h66);
    chk("raw_q_eip",  32'(bus.q_eip),  32'h00100);
`endif

    // 0F 66: byte after 0F is the opcode
    cycle(1, 1, 20'h00200, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, '0, 0, 1);
    cycle(1, 0, '0, 0, 0);
    chk("opx_q_eip", 32'(bus.q_eip), 32'h00200);
`ifdef CORE_PREFETCH_PREFIX_EN
    chk("opx_q_byte",  32'(bus.q_byte),      32'h66);
    chk("opx_opext",   32'(bus.q_prefix[8]), 32'd1);
    chk("opx_q_psize", 32'(bus.q_psize),     32'd1);
`else
    chk("opx_q_byte",  32'(bus.q_byte),  32'h0F);
    chk("opx_q_psize", 32'(bus.q_psize), 32'd0);
`endif

    // randomized traffic: flushes (some near the wrap point), resets, ragged ready/pop
    for (int i = 0; i < 3000; i++) begin
      logic  rn, fl, pp, rd;
      addr_t fe;
      rn = ($urandom_range(0, 499) != 0);
      fl = ($urandom_range(0, 39) == 0);
      fe = ($urandom_range(0, 3) == 0) ? (20'hFFFFC + 20'($urandom_range(0, 3))) : 20'($urandom);
      pp = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 70);
      cycle(rn, fl, fe, pp, rd);
    end
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
